imo_req_responder: RTL

// - Memory-controller end of the IMO request/response link: accepts 128-bit IMO instructions from the Rocket-Chip side.
// - Acks each instruction, decodes the one-hot opcode and executes it:
//   - WR_CR: control-register write.
//   - RLRD / COPY: DRAM command backend.
//   - RNGBUFSZ / RNG: RNG word buffer.
// - Returns 512-bit responses on imo_resp_*. Sits between the IMO controller and the DDR command scheduler.

---
 rtl/imo_req_responder_pkg.sv | 36 +++
 rtl/imo_rng_fifo.sv | 53 +++++
 rtl/imo_req_responder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/imo_req_responder_pkg.sv
// Shared IMO encoding: instruction layout, opcode bit offsets and the opcode decoder.
package imo_req_responder_pkg;

   localparam int INST_W           = 128;
   localparam int RESP_W           = 512;
   localparam int IMO_OP_OFS       = 64;
   localparam int IMO_WR_CR        = 0;
   localparam int IMO_RLRD_OFS     = 1;
   localparam int IMO_COPY_OFS     = 2;
   localparam int IMO_RNGBUFSZ_OFS = 3;
   localparam int IMO_RNG_OFS      = 4;

   typedef enum logic [2:0] {
      OP_WR_CR, OP_RLRD, OP_COPY, OP_BUFSZ, OP_RNG, OP_ILL
   } op_t;

   typedef struct packed {
      op_t         op;
      logic [63:0] arg;
   } req_t;

   // Exactly one recognised bit selects an op; anything else is illegal.
   function automatic op_t decode_op(logic [15:0] op);
      op_t r;
      case (op)
         16'(1) << IMO_WR_CR:        r = OP_WR_CR;
         16'(1) << IMO_RLRD_OFS:     r = OP_RLRD;
         16'(1) << IMO_COPY_OFS:     r = OP_COPY;
         16'(1) << IMO_RNGBUFSZ_OFS: r = OP_BUFSZ;
         16'(1) << IMO_RNG_OFS:      r = OP_RNG;
         default:                    r = OP_ILL;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/imo_rng_fifo.sv
// RNG word buffer: first-word fall-through FIFO, drops pushes while full and flags it stickily.
module imo_rng_fifo #(
   parameter int RNG_W     = 64,
   parameter int RNG_DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [RNG_W-1:0]           push_data,
   input  logic                       pop,
   output logic [RNG_W-1:0]           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(RNG_DEPTH):0] count,
   output logic                       overflow
);

   localparam int AW = $clog2(RNG_DEPTH);
   localparam int CW = AW + 1;

   logic [RNG_W-1:0] mem [RNG_DEPTH];
   logic [AW-1:0]    wptr, rptr;
   logic             do_push, do_pop;

   assign full     = (count == CW'(RNG_DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (push && full) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= push_data;
   end

endmodule

// File: rtl/imo_req_responder.sv
// Memory-controller end of the IMO link: acks and executes one instruction at a time,
// driving CR writes, the DRAM command backend and the RNG buffer, and returns 512-bit responses.
module imo_req_responder
   import imo_req_responder_pkg::*;
#(
   parameter int RNG_W     = 64,
   parameter int RNG_DEPTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_calib_complete,
   input  logic              imo_req_valid,
   input  logic [INST_W-1:0] imo_req_inst,
   output logic              imo_req_ack,
   output logic [RESP_W-1:0] imo_resp_data,
   output logic              imo_resp_valid,
   output logic              cr_wr_en,
   output logic [3:0]        cr_wr_idx,
   output logic [31:0]       cr_wr_data,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic              cmd_op,
   output logic [31:0]       cmd_src,
   output logic [31:0]       cmd_dst,
   input  logic              cmd_done,
   input  logic [RESP_W-1:0] cmd_rdata,
   input  logic              rng_in_valid,
   input  logic [RNG_W-1:0]  rng_in_data,
   output logic              rng_overflow,
   output logic              illegal_op
);

   localparam int CW  = $clog2(RNG_DEPTH) + 1;
   localparam int WPR = RESP_W / RNG_W;
   localparam int KW  = $clog2(WPR) + 1;

   typedef enum logic [2:0] {IDLE, ACK, EXEC, CMD, WAIT, POP, RESP} state_t;

   state_t            state, state_nx;
   req_t              req_q;
   logic [RESP_W-1:0] resp_q;
   logic [KW-1:0]     pop_k, pop_n;
   logic [RNG_W-1:0]  rng_rdata;
   logic [CW-1:0]     rng_count;
   logic              rng_full, rng_empty, rng_pop;
   logic              unused_bits;

   assign unused_bits = ^imo_req_inst[INST_W-1:IMO_OP_OFS+16] ^ rng_full;

   imo_rng_fifo #(.RNG_W(RNG_W), .RNG_DEPTH(RNG_DEPTH)) u_rng (
      .clk       (clk),
      .rst       (rst),
      .push      (rng_in_valid),
      .push_data (rng_in_data),
      .pop       (rng_pop),
      .pop_data  (rng_rdata),
      .full      (rng_full),
      .empty     (rng_empty),
      .count     (rng_count),
      .overflow  (rng_overflow)
   );

   assign imo_resp_data = resp_q;
   assign cr_wr_idx     = req_q.arg[35:32];
   assign cr_wr_data    = req_q.arg[31:0];
   assign cmd_src       = req_q.arg[31:0];
   assign cmd_op        = (req_q.op == OP_COPY);
   assign cmd_dst       = cmd_op ? req_q.arg[63:32] : 32'd0;

   always_comb begin
      state_nx       = state;
      imo_req_ack    = 1'b0;
      imo_resp_valid = 1'b0;
      cr_wr_en       = 1'b0;
      cmd_valid      = 1'b0;
      illegal_op     = 1'b0;
      rng_pop        = 1'b0;
      case (state)
         IDLE: if (init_calib_complete && imo_req_valid) state_nx = ACK;
         ACK: begin
            imo_req_ack = 1'b1;
            state_nx    = EXEC;
         end
         EXEC: begin
            case (req_q.op)
               OP_WR_CR: begin cr_wr_en = 1'b1; state_nx = IDLE; end
               OP_RLRD, OP_COPY: state_nx = CMD;
               OP_BUFSZ: state_nx = RESP;
               OP_RNG:   state_nx = rng_empty ? RESP : POP;
               default: begin illegal_op = 1'b1; state_nx = IDLE; end
            endcase
         end
         CMD: begin
            cmd_valid = 1'b1;
            if (cmd_ready) state_nx = WAIT;
         end
         WAIT: if (cmd_done) state_nx = (req_q.op == OP_RLRD) ? RESP : IDLE;
         POP: begin
            rng_pop = 1'b1;
            if (pop_k == pop_n - 1'b1) state_nx = RESP;
         end
         RESP: begin
            imo_resp_valid = 1'b1;
            state_nx       = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         req_q  <= '0;
         resp_q <= '0;
         pop_k  <= '0;
         pop_n  <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && state_nx == ACK)
            req_q <= '{op: decode_op(imo_req_inst[IMO_OP_OFS+:16]), arg: imo_req_inst[63:0]};
         case (state)
            EXEC: begin
               if (req_q.op == OP_BUFSZ) begin
                  resp_q <= RESP_W'(rng_count);
               end else if (req_q.op == OP_RNG) begin
                  // Word count is frozen here; later pushes never extend this response.
                  resp_q <= '0;
                  pop_k  <= '0;
                  pop_n  <= (int'(rng_count) >= WPR) ? KW'(WPR) : KW'(rng_count);
               end
            end
            POP: begin
               resp_q[pop_k*RNG_W +: RNG_W] <= rng_rdata;
               pop_k <= pop_k + 1'b1;
            end
            WAIT: if (cmd_done && req_q.op == OP_RLRD) resp_q <= cmd_rdata;
            default: ;
         endcase
      end
   end

endmodule
